// File: rtl/usb_tx_encoder_if.sv
// ---------------------------------------------------------------------------
// usb_tx_encoder_if
// Byte handshake between the TX packet FSM (master) and the TX line encoder
// (slave).
//   tx_data  : byte to transmit, LSB goes on the line first
//   tx_last  : marks tx_data as the final byte of the packet
//   tx_valid : tx_data/tx_last are valid
//   tx_ready : encoder holding register can take a byte
// A byte transfers on a clk edge where tx_valid && tx_ready.
// ---------------------------------------------------------------------------
interface usb_tx_encoder_if;
   logic [7:0] tx_data;
   logic       tx_last;
   logic       tx_valid;
   logic       tx_ready;

   modport master (
      output tx_data,
      output tx_last,
      output tx_valid,
      input  tx_ready
   );

   modport slave (
      input  tx_data,
      input  tx_last,
      input  tx_valid,
      output tx_ready
   );
endinterface

// File: rtl/usb_tx_encoder.sv
// ---------------------------------------------------------------------------
// usb_tx_encoder
// Full-speed USB transmit line encoder. Accepts packet bytes through a
// one-byte holding register, serializes them LSB first, inserts stuff bits,
// NRZI-encodes the stream onto dp/dm and finishes with SE0 x EOP_SE0_BITS
// followed by one J. All bit timing comes from bit_strobe.
//
// Parameters:
//   STUFF_LIMIT  : consecutive 1s after which a stuffed 0 is sent (2..7)
//   EOP_SE0_BITS : bit periods of SE0 in the EOP (1..3)
// Build option:
//   USB_TX_BITSTUFF_EN : when defined, bit stuffing is active. When not
//                        defined, data bits go out back to back with no
//                        stuffing (PHY bring-up / eye testing only).
// Ports:
//   clk          : system clock
//   n_rst        : asynchronous active-low reset
//   bit_strobe   : one-cycle pulse at each bit-period boundary
//   tx           : byte handshake (slave side)
//   dp_out/dm_out: line drive (J = 1/0, K = 0/1, SE0 = 0/0)
//   tx_busy      : packet in progress
//   eop_done     : one-cycle pulse after the final EOP J
//   underrun_err : one-cycle pulse when the byte stream starved mid-packet
// ---------------------------------------------------------------------------
module usb_tx_encoder #(
   parameter int STUFF_LIMIT  = 6,
   parameter int EOP_SE0_BITS = 2
) (
   input  logic            clk,
   input  logic            n_rst,
   input  logic            bit_strobe,
   usb_tx_encoder_if.slave tx,
   output logic            dp_out,
   output logic            dm_out,
   output logic            tx_busy,
   output logic            eop_done,
   output logic            underrun_err
);

   generate
      if (STUFF_LIMIT < 2 || STUFF_LIMIT > 7) begin : g_bad_stuff_limit
         $error("usb_tx_encoder: STUFF_LIMIT must be in 2..7");
      end
      if (EOP_SE0_BITS < 1 || EOP_SE0_BITS > 3) begin : g_bad_eop_bits
         $error("usb_tx_encoder: EOP_SE0_BITS must be in 1..3");
      end
   endgenerate

   localparam logic [1:0] SE0_BITS_W = 2'(EOP_SE0_BITS);

   typedef enum logic [1:0] {IDLE, SHIFT, EOP_SE0, EOP_J} state_t;

   state_t      state_reg;
   logic [7:0]  hold_data_reg;
   logic        hold_last_reg;
   logic        hold_full_reg;
   logic        last_accepted_reg;
   logic        tx_ready_reg;
   logic [7:0]  shift_reg;
   logic        cur_last_reg;
   logic [3:0]  bit_idx_reg;     // next data bit to send; 8 = byte finished
   logic [1:0]  se0_cnt_reg;
   logic        nrzi_j_reg;      // 1 while the NRZI line state is J

   logic accept;
   logic stuff_now;
   logic byte_done;
   logic load;
   logic emit;
   logic emit_bit;
   logic line_j_next;
   logic hold_full_next;
   logic last_acc_next;

`ifdef USB_TX_BITSTUFF_EN
   localparam logic [2:0] STUFF_LIMIT_W = 3'(STUFF_LIMIT);
   logic [2:0] ones_cnt_reg;
   logic [2:0] ones_base;
   logic [2:0] ones_next;
`endif

   assign tx.tx_ready = tx_ready_reg;

   always_comb begin
      accept    = tx.tx_valid && tx_ready_reg;
      byte_done = (bit_idx_reg == 4'd8);
`ifdef USB_TX_BITSTUFF_EN
      stuff_now = (state_reg == SHIFT) && (ones_cnt_reg == STUFF_LIMIT_W);
`else
      stuff_now = 1'b0;
`endif
      // A pending stuff bit always goes out before the next byte is loaded.
      load = bit_strobe && hold_full_reg &&
             ((state_reg == IDLE) ||
              ((state_reg == SHIFT) && !stuff_now && byte_done));
      emit = bit_strobe &&
             (load || ((state_reg == SHIFT) && (stuff_now || !byte_done)));

      if (load)
         emit_bit = hold_data_reg[0];
      else if (stuff_now)
         emit_bit = 1'b0;
      else
         emit_bit = shift_reg[bit_idx_reg[2:0]];

      // NRZI: a 0 toggles the line, a 1 holds it.
      line_j_next = emit_bit ? nrzi_j_reg : !nrzi_j_reg;

`ifdef USB_TX_BITSTUFF_EN
      ones_base = (state_reg == IDLE) ? 3'd0 : ones_cnt_reg;
      ones_next = emit_bit ? (ones_base + 3'd1) : 3'd0;
`endif

      // Acceptance and load can never coincide: load needs hold_full, which
      // keeps tx_ready low.
      if (accept)
         hold_full_next = 1'b1;
      else if (load)
         hold_full_next = 1'b0;
      else
         hold_full_next = hold_full_reg;

      // A new last byte accepted as the previous packet finishes wins.
      if (accept && tx.tx_last)
         last_acc_next = 1'b1;
      else if (state_reg == EOP_J)
         last_acc_next = 1'b0;
      else
         last_acc_next = last_accepted_reg;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_reg         <= IDLE;
         hold_data_reg     <= 8'h00;
         hold_last_reg     <= 1'b0;
         hold_full_reg     <= 1'b0;
         last_accepted_reg <= 1'b0;
         tx_ready_reg      <= 1'b1;
         shift_reg         <= 8'h00;
         cur_last_reg      <= 1'b0;
         bit_idx_reg       <= 4'd0;
         se0_cnt_reg       <= 2'd0;
         nrzi_j_reg        <= 1'b1;
         dp_out            <= 1'b1;
         dm_out            <= 1'b0;
         tx_busy           <= 1'b0;
         eop_done          <= 1'b0;
         underrun_err      <= 1'b0;
`ifdef USB_TX_BITSTUFF_EN
         ones_cnt_reg      <= 3'd0;
`endif
      end else begin
         eop_done     <= 1'b0;
         underrun_err <= 1'b0;

         if (accept) begin
            hold_data_reg <= tx.tx_data;
            hold_last_reg <= tx.tx_last;
         end
         hold_full_reg     <= hold_full_next;
         last_accepted_reg <= last_acc_next;
         tx_ready_reg      <= !hold_full_next && !last_acc_next;

         if (load) begin
            shift_reg    <= hold_data_reg;
            cur_last_reg <= hold_last_reg;
            bit_idx_reg  <= 4'd1;
         end

         if (emit) begin
            nrzi_j_reg <= line_j_next;
            dp_out     <= line_j_next;
            dm_out     <= !line_j_next;
`ifdef USB_TX_BITSTUFF_EN
            ones_cnt_reg <= ones_next;
`endif
         end

         case (state_reg)
            IDLE: begin
               if (load) begin
                  state_reg <= SHIFT;
                  tx_busy   <= 1'b1;
               end
            end
            SHIFT: begin
               if (bit_strobe && !stuff_now && !load) begin
                  if (!byte_done) begin
                     bit_idx_reg <= bit_idx_reg + 4'd1;
                  end else begin
                     // Byte finished with nothing queued: normal end of
                     // packet if it was the last byte, otherwise abort.
                     state_reg    <= EOP_SE0;
                     dp_out       <= 1'b0;
                     dm_out       <= 1'b0;
                     nrzi_j_reg   <= 1'b1;
                     se0_cnt_reg  <= 2'd1;
                     underrun_err <= !cur_last_reg;
                  end
               end
            end
            EOP_SE0: begin
               if (bit_strobe) begin
                  if (se0_cnt_reg == SE0_BITS_W) begin
                     state_reg <= EOP_J;
                     dp_out    <= 1'b1;
                     dm_out    <= 1'b0;
                  end else begin
                     se0_cnt_reg <= se0_cnt_reg + 2'd1;
                  end
               end
            end
            EOP_J: begin
               state_reg <= IDLE;
               eop_done  <= 1'b1;
               tx_busy   <= 1'b0;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_usb_tx_encoder.sv
// ---------------------------------------------------------------------------
// tb_usb_tx_encoder
// Directed bench for usb_tx_encoder. Bytes to send go into feed_q; the line
// symbols expected on each bit strobe go into exp_q and are popped and
// compared as the encoder drives them. Bit period = 4 clocks.
// Symbols: J = {dp,dm} 2'b10, K = 2'b01, SE0 = 2'b00.
// ---------------------------------------------------------------------------
module tb_usb_tx_encoder;

   logic clk = 1'b0;
   logic n_rst = 1'b0;
   logic bit_strobe = 1'b0;
   logic dp_out, dm_out, tx_busy, eop_done, underrun_err;

   usb_tx_encoder_if ifc ();

   usb_tx_encoder dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .bit_strobe   (bit_strobe),
      .tx           (ifc.slave),
      .dp_out       (dp_out),
      .dm_out       (dm_out),
      .tx_busy      (tx_busy),
      .eop_done     (eop_done),
      .underrun_err (underrun_err)
   );

   always #5 clk = ~clk;

   localparam logic [1:0] SYM_J   = 2'b10;
   localparam logic [1:0] SYM_K   = 2'b01;
   localparam logic [1:0] SYM_SE0 = 2'b00;

   logic [8:0] feed_q[$];   // {last, data}
   logic [1:0] exp_q[$];

   int total = 0;
   int bad   = 0;

   int strobe_num, cyc_since, eop_cnt, eop_strobe, eop_delay;
   int und_cnt, und_strobe, ready_rises;
   logic eop_busy, busy_first, prev_ready;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_str(input string s);
      for (int i = 0; i < s.len(); i++) begin
         if (s[i] == "J")      exp_q.push_back(SYM_J);
         else if (s[i] == "K") exp_q.push_back(SYM_K);
         else                  exp_q.push_back(SYM_SE0);
      end
   endtask

   task automatic clear_stats();
      strobe_num  = 0; cyc_since = 0; eop_cnt = 0; eop_strobe = 0;
      eop_delay   = 0; und_cnt = 0; und_strobe = 0; ready_rises = 0;
      eop_busy    = 1'bx; busy_first = 1'bx; prev_ready = ifc.tx_ready;
   endtask

   // One clock. Entered and left just after a falling edge.
   task automatic cyc(input logic strobe);
      logic acc;
      logic [1:0] e;
      bit_strobe = strobe;
      if (!ifc.tx_valid && feed_q.size() > 0) begin
         {ifc.tx_last, ifc.tx_data} = feed_q[0];
         ifc.tx_valid = 1'b1;
      end
      acc = ifc.tx_valid && ifc.tx_ready;
      @(posedge clk);
      #1;
      bit_strobe = 1'b0;
      if (acc) begin
         void'(feed_q.pop_front());
         if (feed_q.size() > 0) {ifc.tx_last, ifc.tx_data} = feed_q[0];
         else ifc.tx_valid = 1'b0;
      end
      @(negedge clk);
      if (strobe) begin
         strobe_num++;
         cyc_since = 0;
      end else begin
         cyc_since++;
      end
      if (ifc.tx_ready && !prev_ready) ready_rises++;
      prev_ready = ifc.tx_ready;
      if (strobe && strobe_num == 1) busy_first = tx_busy;
      if (eop_done) begin
         eop_cnt++; eop_strobe = strobe_num; eop_delay = cyc_since; eop_busy = tx_busy;
      end
      if (underrun_err) begin
         und_cnt++; und_strobe = strobe_num;
      end
      if (strobe) begin
         if (exp_q.size() == 0) begin
            chk($sformatf("idle_line_s%0d", strobe_num), {30'd0, dp_out, dm_out}, {30'd0, SYM_J});
         end else begin
            e = exp_q.pop_front();
            chk($sformatf("line_s%0d", strobe_num), {30'd0, dp_out, dm_out}, {30'd0, e});
            $display("strobe %0d: dp=%0b dm=%0b busy=%0b", strobe_num, dp_out, dm_out, tx_busy);
         end
      end
   endtask

   task automatic period();
      cyc(1'b1); cyc(1'b0); cyc(1'b0); cyc(1'b0);
   endtask

   task automatic run_packet();
      int n;
      clear_stats();
      n = 0;
      while (exp_q.size() > 0 && n < 100) begin
         period();
         n++;
      end
      chk("expected_drained", exp_q.size(), 0);
      cyc(1'b0); cyc(1'b0);
   endtask

   initial begin
      ifc.tx_data = 8'h00; ifc.tx_last = 1'b0; ifc.tx_valid = 1'b0;
      clear_stats();
      repeat (3) @(negedge clk);
      n_rst = 1'b1;
      @(negedge clk);

      // Reset state
      chk("rst_dp", dp_out, 1'b1);
      chk("rst_dm", dm_out, 1'b0);
      chk("rst_ready", ifc.tx_ready, 1'b1);
      chk("rst_busy", tx_busy, 1'b0);
      chk("rst_eop", eop_done, 1'b0);
      chk("rst_underrun", underrun_err, 1'b0);

      // Single SYNC packet
      feed_q.push_back({1'b1, 8'h80});
      cyc(1'b0); cyc(1'b0);
      chk("sync_hold_ready", ifc.tx_ready, 1'b0);
      chk("sync_pre_busy", tx_busy, 1'b0);
      chk("sync_pre_line", {dp_out, dm_out}, SYM_J);
      push_str("KJKJKJKK00J");
      run_packet();
      chk("sync_busy_first", busy_first, 1'b1);
      chk("sync_eop_cnt", eop_cnt, 1);
      chk("sync_eop_strobe", eop_strobe, 11);
      chk("sync_eop_delay", eop_delay, 1);
      chk("sync_eop_busy", eop_busy, 1'b0);
      chk("sync_underrun", und_cnt, 0);
      chk("sync_ready_end", ifc.tx_ready, 1'b1);

      // Stuffing across a byte boundary
      feed_q.push_back({1'b0, 8'h80});
      feed_q.push_back({1'b1, 8'hFF});
      cyc(1'b0); cyc(1'b0);
      push_str("KJKJKJKK");
`ifdef USB_TX_BITSTUFF_EN
      push_str("KKKKKJJJJ");
`else
      push_str("KKKKKKKK");
`endif
      push_str("00J");
      run_packet();
      chk("stuff_eop_cnt", eop_cnt, 1);
`ifdef USB_TX_BITSTUFF_EN
      chk("stuff_eop_strobe", eop_strobe, 20);
`else
      chk("stuff_eop_strobe", eop_strobe, 19);
`endif
      chk("stuff_underrun", und_cnt, 0);

      // Back-to-back bytes with tx_valid held
      feed_q.push_back({1'b0, 8'h80});
      feed_q.push_back({1'b0, 8'h00});
      feed_q.push_back({1'b1, 8'h00});
      cyc(1'b0); cyc(1'b0);
      push_str("KJKJKJKKJKJKJKJKJKJKJKJK00J");
      run_packet();
      chk("b2b_eop_cnt", eop_cnt, 1);
      chk("b2b_eop_strobe", eop_strobe, 27);
      chk("b2b_ready_rises", ready_rises, 3);
      chk("b2b_feed_empty", feed_q.size(), 0);

      // Underrun; byte offered on the same edge as a strobe, so the first
      // strobe still sees an idle line.
      feed_q.push_back({1'b0, 8'h80});
      push_str("JKJKJKJKK00J");
      run_packet();
      chk("und_cnt", und_cnt, 1);
      chk("und_strobe", und_strobe, 10);
      chk("und_eop_cnt", eop_cnt, 1);
      chk("und_eop_strobe", eop_strobe, 12);
      chk("und_ready_end", ifc.tx_ready, 1'b1);
      chk("und_busy_end", tx_busy, 1'b0);

      // Reset in the middle of SHIFT
      feed_q.push_back({1'b0, 8'h80});
      feed_q.push_back({1'b1, 8'hFF});
      cyc(1'b0); cyc(1'b0);
      clear_stats();
      push_str("KJK");
      period(); period(); period();
      chk("mid_busy", tx_busy, 1'b1);
      #2;
      n_rst = 1'b0;
      #1;
      chk("mid_rst_dp", dp_out, 1'b1);
      chk("mid_rst_dm", dm_out, 1'b0);
      chk("mid_rst_ready", ifc.tx_ready, 1'b1);
      chk("mid_rst_busy", tx_busy, 1'b0);
      feed_q.delete();
      exp_q.delete();
      ifc.tx_valid = 1'b0;
      @(negedge clk);
      n_rst = 1'b1;
      clear_stats();
      period(); period();
      chk("post_rst_busy", tx_busy, 1'b0);
      chk("post_rst_eop", eop_cnt, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
